mem_store_aligner: RTL and testbench
====================================

# mem_store_aligner

Store-path counterpart of the load sign extender: takes a RISC-V store (SB/SH/SW) from the execute stage and writes it to a 32-bit word-addressed data memory port. It shifts store data into the correct byte lanes and generates byte enables. It splits any store that crosses a word boundary into two word writes, handshaking each beat with the memory.

## Interface
- No parameters; data path fixed at 32 bits, byte-lane memory.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- StoreValid  input  1  store request present.
- StoreReady  output  1  block can accept a request; high only in IDLE.
- StoreAddr  input  32  byte address of store.
- StoreData  input  32  rs2 value; the low byte, halfword or word is used.
- funct3  input  3  000=SB, 001=SH, 010=SW; any other value is a fault.
- MemWrEn  output  1  write beat valid.
- MemWrAddr  output  32  word-aligned address, bits [1:0] always 00.
- MemWrData  output  32  lane-aligned write data; unused lanes are 0.
- MemByteEn  output  4  per-lane write enable; bit i enables bits [8i+7:8i].
- MemWrAck  input  1  memory accepts the current beat.
- StoreDone  output  1  one-cycle pulse: store fully written.
- StoreFault  output  1  one-cycle pulse: illegal funct3, nothing written.

## Operation
- States: IDLE, BEAT0, BEAT1.
- Accept happens on a rising edge with StoreValid=1 and StoreReady=1. At accept, latch:
  - base = {StoreAddr[31:2],2'b00}
  - off = StoreAddr[1:0]
  - data = StoreData
  - mask = 0001 (SB), 0011 (SH) or 1111 (SW)
- At accept with illegal funct3: stay in IDLE and pulse StoreFault for the following cycle. No memory beat is issued.
- Derived values:
  - lanes8 = {4'b0,mask} << off (8 bits).
  - wide = {32'b0,data} << (8*off) (64 bits; the mask zeroes unused bytes first).
- BEAT0 drives:
  - MemWrEn=1
  - MemWrAddr=base
  - MemWrData=wide[31:0] with non-enabled lanes 0
  - MemByteEn=lanes8[3:0]
- BEAT0 exit on a rising edge with MemWrAck=1:
  - If lanes8[7:4]!=0, go to BEAT1.
  - Otherwise go to IDLE and pulse StoreDone.
- BEAT1 drives:
  - MemWrEn=1
  - MemWrAddr=base+4, wrapping modulo 2^32
  - MemWrData=wide[63:32] with non-enabled lanes 0
  - MemByteEn=lanes8[7:4]
- BEAT1 exit: on MemWrAck=1, go to IDLE and pulse StoreDone.
- Split cases are SH at off=3 and SW at off=1, 2 or 3. SB never splits.
- In IDLE: MemWrEn=0, MemByteEn=0, MemWrAddr=0, MemWrData=0.
- MemWrAck is ignored while MemWrEn=0.
- StoreValid is ignored outside IDLE. Upstream holds the request until it sees StoreReady.

## Timing
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- Reset values: state IDLE, StoreReady=1, MemWrEn=0, MemWrAddr=0, MemWrData=0, MemByteEn=0, StoreDone=0, StoreFault=0.
- Reset asserted mid-store (BEAT0 or BEAT1) aborts the store:
  - MemWrEn=0 in the cycle after the reset edge.
  - No further beat is issued and no StoreDone pulse occurs.
- Non-split store with immediate ack: accept at edge N; BEAT0 during cycle N+1; ack at edge N+1; IDLE and StoreDone=1 during cycle N+2. Next accept is possible at edge N+2.
- Split store adds one cycle per beat. Each beat is extended by one cycle for each cycle MemWrAck stays low.
- While MemWrEn=1 and MemWrAck=0, MemWrAddr, MemWrData and MemByteEn hold stable.
- StoreDone and StoreFault are never high together, and each is high for exactly one cycle.
- A new accept may occur in the same cycle StoreDone or StoreFault is high.

## Test plan
- SB, StoreAddr=0x00001003, StoreData=0xAABBCCDD, ack immediate -> one beat: addr 0x00001000, ByteEn 1000, data 0xDD000000; StoreDone 2 cycles after accept.
- SH, StoreAddr=0x00002002, StoreData=0xFFFF1234 -> one beat: addr 0x00002000, ByteEn 1100, data 0x12340000.
- SW, StoreAddr=0x00003001, StoreData=0x11223344 -> beat0: 0x00003000, 1110, 0x22334400; then beat1: 0x00003004, 0001, 0x00000011; StoreDone after the second ack.
- SH, StoreAddr=0xFFFFFFFF, StoreData=0x0000BEEF -> beat0: 0xFFFFFFFC, 1000, 0xEF000000; beat1 wraps to 0x00000000, 0001, 0x000000BE.
- SW at 0x00004000 with MemWrAck low for 5 cycles -> MemWrEn, addr, data and ByteEn stable for all 6 cycles, StoreReady=0 throughout. Separately, reset asserted during BEAT1 of a split SW -> MemWrEn=0, StoreReady=1 next cycle, no StoreDone.
- funct3=011 with StoreValid=1 -> StoreFault=1 for exactly one cycle, MemWrEn never asserted. Then a valid SB accepted the next cycle proceeds normally.

Source files
------------

// File: rtl/mem_store_aligner_if.sv
// Store request and memory write-port bundle between the execute stage, the
// store aligner and the word-addressed data memory.
interface mem_store_aligner_if;
   logic        StoreValid;
   logic        StoreReady;
   logic [31:0] StoreAddr;
   logic [31:0] StoreData;
   logic [2:0]  funct3;
   logic        MemWrEn;
   logic [31:0] MemWrAddr;
   logic [31:0] MemWrData;
   logic [3:0]  MemByteEn;
   logic        MemWrAck;
   logic        StoreDone;
   logic        StoreFault;

   // master: the execute stage plus the memory's ack; slave: the aligner.
   modport master (
      output StoreValid, StoreAddr, StoreData, funct3, MemWrAck,
      input  StoreReady, MemWrEn, MemWrAddr, MemWrData, MemByteEn,
             StoreDone, StoreFault
   );

   modport slave (
      input  StoreValid, StoreAddr, StoreData, funct3, MemWrAck,
      output StoreReady, MemWrEn, MemWrAddr, MemWrData, MemByteEn,
             StoreDone, StoreFault
   );
endinterface

// File: rtl/mem_store_aligner.sv
// RISC-V SB/SH/SW store aligner: lane-shifts store data, builds byte enables and
// splits word-crossing stores into two handshaked memory beats.
//
// state | meaning
// IDLE  | ready for a store request, memory port quiet
// BEAT0 | writing the word holding the lowest addressed byte
// BEAT1 | writing the spill-over into the next word (split stores only)
module mem_store_aligner (
   input  logic                 clk,
   input  logic                 reset,
   mem_store_aligner_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      state;
   logic        ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  byte_en;
   logic        done;
   logic        fault;
   logic [31:0] hi_data;
   logic [3:0]  hi_be;

   logic        legal;
   logic [3:0]  mask;
   logic [31:0] byte_mask;
   logic [1:0]  off;
   logic [7:0]  lanes8;
   logic [63:0] wide;

   always_comb begin
      legal = 1'b1;
      mask  = 4'b0000;
      case (bus.funct3)
         3'b000:  mask = 4'b0001;
         3'b001:  mask = 4'b0011;
         3'b010:  mask = 4'b1111;
         default: legal = 1'b0;
      endcase
      byte_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
      off       = bus.StoreAddr[1:0];
      // Mask before shifting so unused source bytes never reach a lane.
      wide      = {32'b0, bus.StoreData & byte_mask} << {off, 3'b000};
      lanes8    = {4'b0000, mask} << off;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ready   <= 1'b1;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         byte_en <= '0;
         done    <= 1'b0;
         fault   <= 1'b0;
         hi_data <= '0;
         hi_be   <= '0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.StoreValid) begin
                  if (legal) begin
                     state   <= BEAT0;
                     ready   <= 1'b0;
                     wr_en   <= 1'b1;
                     wr_addr <= {bus.StoreAddr[31:2], 2'b00};
                     wr_data <= wide[31:0];
                     byte_en <= lanes8[3:0];
                     hi_data <= wide[63:32];
                     hi_be   <= lanes8[7:4];
                  end else begin
                     fault <= 1'b1;
                  end
               end
            end
            BEAT0: begin
               if (bus.MemWrAck) begin
                  if (hi_be != 4'b0000) begin
                     state   <= BEAT1;
                     wr_addr <= wr_addr + 32'd4;
                     wr_data <= hi_data;
                     byte_en <= hi_be;
                  end else begin
                     state   <= IDLE;
                     ready   <= 1'b1;
                     wr_en   <= 1'b0;
                     wr_addr <= '0;
                     wr_data <= '0;
                     byte_en <= '0;
                     done    <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (bus.MemWrAck) begin
                  state   <= IDLE;
                  ready   <= 1'b1;
                  wr_en   <= 1'b0;
                  wr_addr <= '0;
                  wr_data <= '0;
                  byte_en <= '0;
                  done    <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               ready   <= 1'b1;
               wr_en   <= 1'b0;
               wr_addr <= '0;
               wr_data <= '0;
               byte_en <= '0;
            end
         endcase
      end
   end

   assign bus.StoreReady = ready;
   assign bus.MemWrEn    = wr_en;
   assign bus.MemWrAddr  = wr_addr;
   assign bus.MemWrData  = wr_data;
   assign bus.MemByteEn  = byte_en;
   assign bus.StoreDone  = done;
   assign bus.StoreFault = fault;
endmodule

// File: tb/tb_mem_store_aligner.sv
// Scoreboard bench for mem_store_aligner: a byte-by-byte store model predicts the
// memory beats and done/fault events; a negedge monitor checks what the DUT shows.
module tb_mem_store_aligner;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_store_aligner_if bus ();

   mem_store_aligner dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } beat_t;

   beat_t      exp_beats[$];
   logic [7:0] evq[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         ack_mode = 1;   // 0 random, 1 always high, 2 held low
   bit         run = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk the stored bytes one address at a time and group them by word.
   task automatic push_model(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
      beat_t       b;
      bit          open;
      logic [31:0] ba;
      logic [31:0] w;
      int          n;
      open = 1'b0;
      b = '0;
      if (f3 > 3'd2) begin
         evq.push_back(8'h46);
         return;
      end
      n = 1 << f3;
      for (int i = 0; i < n; i++) begin
         ba = addr + 32'(i);
         w  = {ba[31:2], 2'b00};
         if (open && w != b.a) begin
            exp_beats.push_back(b);
            open = 1'b0;
         end
         if (!open) begin
            b.a = w; b.d = '0; b.be = '0; open = 1'b1;
         end
         b.d = b.d | (32'(data[8*i +: 8]) << (8 * int'(ba[1:0])));
         b.be[ba[1:0]] = 1'b1;
      end
      exp_beats.push_back(b);
      evq.push_back(8'h44);
   endtask

   initial begin
      bus.MemWrAck = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ack_mode)
            0:       bus.MemWrAck = ($urandom_range(0, 9) < 7);
            1:       bus.MemWrAck = 1'b1;
            default: bus.MemWrAck = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      beat_t      b;
      logic [7:0] e;
      if (run && !reset) begin
         check("ready_vs_en", 64'(bus.StoreReady), 64'(!bus.MemWrEn));
         check("done_fault_excl", 64'(bus.StoreDone && bus.StoreFault), 64'd0);
         if (bus.MemWrEn) begin
            if (exp_beats.size() == 0) begin
               check("unexpected_beat", 64'd1, 64'd0);
            end else begin
               b = exp_beats[0];
               check("beat_addr", 64'(bus.MemWrAddr), 64'(b.a));
               check("beat_data", 64'(bus.MemWrData), 64'(b.d));
               check("beat_be", 64'(bus.MemByteEn), 64'(b.be));
               if (bus.MemWrAck) void'(exp_beats.pop_front());
            end
         end else begin
            check("idle_addr", 64'(bus.MemWrAddr), 64'd0);
            check("idle_data_be", 64'({bus.MemWrData, bus.MemByteEn}), 64'd0);
         end
         if (bus.StoreDone || bus.StoreFault) begin
            if (evq.size() == 0) begin
               check("unexpected_event", 64'd1, 64'd0);
            end else begin
               e = evq.pop_front();
               check("event_kind", 64'(bus.StoreDone ? 8'h44 : 8'h46), 64'(e));
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      int t;
      t = 0;
      bus.StoreValid = 1'b1;
      bus.StoreAddr  = a;
      bus.StoreData  = d;
      bus.funct3     = f3;
      @(negedge clk);
      while (!bus.StoreReady && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.StoreReady) begin
         check("accept_timeout", 64'd1, 64'd0);
      end else begin
         push_model(a, d, f3);
      end
      @(posedge clk);
      #1;
      bus.StoreValid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_beats.size() != 0 || evq.size() != 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", 64'(exp_beats.size() + evq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra;
      logic [2:0]  rf;
      bus.StoreValid = 1'b0;
      bus.StoreAddr  = '0;
      bus.StoreData  = '0;
      bus.funct3     = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(bus.StoreReady), 64'd1);
      check("rst_en", 64'(bus.MemWrEn), 64'd0);
      check("rst_bus", 64'({bus.MemWrAddr, bus.MemWrData}), 64'd0);
      check("rst_be_pulses", 64'({bus.MemByteEn, bus.StoreDone, bus.StoreFault}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run = 1'b1;

      // SB at off 3, immediate ack: done two cycles after accept
      ack_mode = 1;
      do_store(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
      @(negedge clk);
      check("sb_beat_cycle_en", 64'({bus.MemWrEn, bus.StoreDone}), 64'b10);
      @(negedge clk);
      check("sb_done_cycle", 64'({bus.MemWrEn, bus.StoreDone}), 64'b01);
      wait_idle();

      do_store(32'h0000_2002, 32'hFFFF_1234, 3'b001);
      wait_idle();
      do_store(32'h0000_3001, 32'h1122_3344, 3'b010);
      wait_idle();
      do_store(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001);
      wait_idle();

      // SW with ack held low for five cycles
      ack_mode = 2;
      do_store(32'h0000_4000, 32'hCAFE_F00D, 3'b010);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("stall_en_ready", 64'({bus.MemWrEn, bus.StoreReady}), 64'b10);
         if (k == 4) ack_mode = 1;
      end
      wait_idle();

      // Reset during BEAT1 of a split SW aborts it
      ack_mode = 2;
      do_store(32'h0000_5002, 32'h8765_4321, 3'b010);
      @(negedge clk);
      ack_mode = 1;
      @(negedge clk);
      ack_mode = 2;
      @(negedge clk);
      check("beat1_before_rst", 64'({bus.MemWrEn, bus.MemByteEn}), 64'b1_0011);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_beats.delete();
      evq.delete();
      @(negedge clk);
      check("abort_en_ready", 64'({bus.MemWrEn, bus.StoreReady, bus.StoreDone}), 64'b010);
      ack_mode = 1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;

      // Illegal funct3, then an SB accepted while StoreFault is high
      do_store(32'h0000_6000, 32'h1234_5678, 3'b011);
      bus.StoreValid = 1'b1;
      bus.StoreAddr  = 32'h0000_6001;
      bus.StoreData  = 32'h0000_00A5;
      bus.funct3     = 3'b000;
      @(negedge clk);
      check("fault_cycle", 64'({bus.StoreFault, bus.MemWrEn, bus.StoreReady}), 64'b101);
      push_model(32'h0000_6001, 32'h0000_00A5, 3'b000);
      @(posedge clk);
      #1;
      bus.StoreValid = 1'b0;
      @(negedge clk);
      check("after_fault", 64'({bus.StoreFault, bus.MemWrEn}), 64'b01);
      wait_idle();

      // Randomised traffic with random ack stalls
      ack_mode = 0;
      for (int n = 0; n < 300; n++) begin
         rf = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra[31:2] = '1;
         do_store(ra, $urandom, rf);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      ack_mode = 1;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
